cla_subtractor_pipe: RTL and testbench

- Two-stage pipelined subtractor: computes a - b - bin using the 4-bit carry-lookahead group structure already used by the team's adder.
- Each stage resolves one half of the operand, split at a 4-bit group boundary, with the group carry passed between stages.
- Valid/ready handshake on both sides so it drops into the datapath with back-pressure.
- Also produces the flags the ALU status logic needs.

---
 rtl/cla_subtractor_pipe.sv | 146 ++++++++++++++
 tb/tb_cla_subtractor_pipe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_subtractor_pipe.sv
// Two-stage pipelined a - b - bin built from 4-bit carry-lookahead groups.
// Low half resolves in stage 1, high half in stage 2; valid/ready on both sides.
module cla_subtractor_pipe #(
  parameter int WIDTH = 8,
  parameter int LO_W  = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] carry,
  output logic             borrow,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  localparam int HI_W = WIDTH - LO_W;

  // Returns carries c1..c4 of one lookahead group, fully expanded.
  function automatic logic [3:0] cla4(input logic [3:0] g, input logic [3:0] p,
                                      input logic c0);
    logic [3:0] c;
    c[0] = g[0] | (p[0] & c0);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  logic             s1_valid;
  logic             s2_free;
  logic             s1_load;
  logic             s1_adv;

  logic [LO_W-1:0]  s1_diff_lo;
  logic [LO_W-1:0]  s1_carry_lo;
  logic             s1_cout;
  logic [HI_W-1:0]  s1_a_hi;
  logic [HI_W-1:0]  s1_b_hi;
  logic             s1_a_sign;
  logic             s1_b_sign;

  logic [LO_W-1:0]  lo_diff;
  logic [LO_W-1:0]  lo_carry;
  logic             lo_cout;
  logic [HI_W-1:0]  hi_diff;
  logic [HI_W-1:0]  hi_carry;
  logic             hi_cout;

  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_free;
  assign s1_load  = in_valid && in_ready;
  assign s1_adv   = s1_valid && s2_free;

  // Subtraction as a + ~b + ~bin; group carries ripple between groups.
  always_comb begin : lo_half
    logic [LO_W-1:0] g;
    logic [LO_W-1:0] p;
    logic [LO_W:0]   c;
    g    = a[LO_W-1:0] & ~b[LO_W-1:0];
    p    = a[LO_W-1:0] ^ ~b[LO_W-1:0];
    c    = '0;
    c[0] = ~bin;
    for (int k = 0; k < LO_W / 4; k++) begin
      c[4*k+1 +: 4] = cla4(g[4*k +: 4], p[4*k +: 4], c[4*k]);
    end
    lo_diff  = p ^ c[LO_W-1:0];
    lo_carry = c[LO_W:1];
    lo_cout  = c[LO_W];
  end

  always_comb begin : hi_half
    logic [HI_W-1:0] g;
    logic [HI_W-1:0] p;
    logic [HI_W:0]   c;
    g    = s1_a_hi & ~s1_b_hi;
    p    = s1_a_hi ^ ~s1_b_hi;
    c    = '0;
    c[0] = s1_cout;
    for (int k = 0; k < HI_W / 4; k++) begin
      c[4*k+1 +: 4] = cla4(g[4*k +: 4], p[4*k +: 4], c[4*k]);
    end
    hi_diff  = p ^ c[HI_W-1:0];
    hi_carry = c[HI_W:1];
    hi_cout  = c[HI_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (s1_load)     s1_valid <= 1'b1;
      else if (s1_adv) s1_valid <= 1'b0;
      if (s1_adv)         out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_diff_lo  <= '0;
      s1_carry_lo <= '0;
      s1_cout     <= 1'b0;
      s1_a_hi     <= '0;
      s1_b_hi     <= '0;
      s1_a_sign   <= 1'b0;
      s1_b_sign   <= 1'b0;
    end else if (s1_load) begin
      s1_diff_lo  <= lo_diff;
      s1_carry_lo <= lo_carry;
      s1_cout     <= lo_cout;
      s1_a_hi     <= a[WIDTH-1:LO_W];
      s1_b_hi     <= b[WIDTH-1:LO_W];
      s1_a_sign   <= a[WIDTH-1];
      s1_b_sign   <= b[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff     <= '0;
      carry    <= '0;
      borrow   <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
      overflow <= 1'b0;
    end else if (s1_adv) begin
      diff     <= {hi_diff, s1_diff_lo};
      carry    <= {hi_carry, s1_carry_lo};
      borrow   <= ~hi_cout;
      zero     <= ({hi_diff, s1_diff_lo} == '0);
      negative <= hi_diff[HI_W-1];
      overflow <= (s1_a_sign ^ s1_b_sign) & (hi_diff[HI_W-1] ^ s1_a_sign);
    end
  end

endmodule

// File: tb/tb_cla_subtractor_pipe.sv
// Random and directed bench for cla_subtractor_pipe against an arithmetic model.
module tb_cla_subtractor_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       bin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] diff;
  logic [7:0] carry;
  logic       borrow;
  logic       zero;
  logic       negative;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] diff;
    logic [7:0] carry;
    logic       borrow;
    logic       zero;
    logic       neg;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];

  cla_subtractor_pipe #(.WIDTH(8), .LO_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .carry(carry), .borrow(borrow), .zero(zero),
    .negative(negative), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Carry into bit i+1 is whether the i+1 low-order bits of a + ~b + ~bin overflow.
  function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv, input logic binv);
    exp_t m;
    int   d;
    int   s;
    int   nb;
    int   cin;
    int   md;
    nb  = 255 - int'(bv);
    cin = binv ? 0 : 1;
    d   = int'(av) - int'(bv) - int'(binv);
    m.diff = d[7:0];
    for (int i = 0; i < 8; i++) begin
      md = 1 << (i + 1);
      s  = (int'(av) % md) + (nb % md) + cin;
      m.carry[i] = (s >= md);
    end
    m.borrow = int'(av) < (int'(bv) + int'(binv));
    m.zero   = (m.diff == 8'h00);
    m.neg    = m.diff[7];
    m.ovf    = (av[7] != bv[7]) && (m.diff[7] != av[7]);
    return m;
  endfunction

  // Scoreboard and stall-stability monitor, sampled on the falling edge.
  initial begin : monitor
    logic       held_vld;
    logic [7:0] held_diff;
    logic [7:0] held_carry;
    exp_t       e;
    held_vld = 1'b0;
    held_diff = '0;
    held_carry = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_vld = 1'b0;
      end else begin
        if (held_vld) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_diff", diff, held_diff);
          chk("hold_carry", carry, held_carry);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("pop_unexpected", out_valid, 0);
          end else begin
            e = exp_q.pop_front();
            chk("diff", diff, e.diff);
            chk("carry", carry, e.carry);
            chk("borrow", borrow, e.borrow);
            chk("zero", zero, e.zero);
            chk("negative", negative, e.neg);
            chk("overflow", overflow, e.ovf);
          end
        end
        if (in_valid && in_ready) exp_q.push_back(model(a, b, bin));
        held_vld   = out_valid && !out_ready;
        held_diff  = diff;
        held_carry = carry;
      end
    end
  end

  task automatic drive(input logic [7:0] av, input logic [7:0] bv, input logic binv);
    int n;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = av;
    b = bv;
    bin = binv;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    chk("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    logic acc;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_diff", diff, 0);
    chk("rst_carry", carry, 0);

    // Zero operands: latency 2 and the documented flag values.
    drive(8'h00, 8'h00, 1'b0);
    @(negedge clk);
    chk("lat_cycle1", out_valid, 0);
    @(negedge clk);
    chk("lat_cycle2", out_valid, 1);
    chk("zz_diff", diff, 8'h00);
    chk("zz_carry", carry, 8'hFF);
    chk("zz_zero", zero, 1);
    chk("zz_borrow", borrow, 0);

    drive(8'h10, 8'h01, 1'b0);
    drive(8'h05, 8'h0A, 1'b0);
    drive(8'h80, 8'h01, 1'b0);
    drive(8'h00, 8'h00, 1'b1);
    drive(8'hFF, 8'h00, 1'b1);
    drive(8'h7F, 8'h80, 1'b0);
    drain();

    // Back-pressure: two accepts fill the pipe, third waits until release.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 8'h09; b = 8'h03; bin = 1'b0;
    @(negedge clk);
    chk("bp_ready0", in_ready, 1);
    @(posedge clk);
    #1;
    a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    chk("bp_ready1", in_ready, 1);
    @(posedge clk);
    #1;
    a = 8'h3C; b = 8'h0F;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_blocked", in_ready, 0);
      chk("bp_first_held", diff, 8'h06);
      if (i < 3) @(posedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_pop0_valid", out_valid, 1);
    chk("bp_pop0", diff, 8'h06);
    chk("bp_ready_rel", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_pop1_valid", out_valid, 1);
    chk("bp_pop1", diff, 8'h00);
    @(negedge clk);
    chk("bp_pop2_valid", out_valid, 1);
    chk("bp_pop2", diff, 8'h2D);
    drain();

    // Asynchronous reset while both stages are full and stalled.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 8'h55; b = 8'h22; bin = 1'b0;
    @(posedge clk);
    #1;
    a = 8'hA0; b = 8'h0B; bin = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rs_full_valid", out_valid, 1);
    chk("rs_full_ready", in_ready, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rs_out_valid", out_valid, 0);
    chk("rs_diff", diff, 0);
    chk("rs_carry", carry, 0);
    chk("rs_flags", {borrow, zero, negative, overflow}, 4'b0000);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rs_in_ready", in_ready, 1);
    chk("rs_still_empty", out_valid, 0);
    drive(8'h80, 8'h01, 1'b0);
    @(negedge clk);
    chk("rs_lat1", out_valid, 0);
    @(negedge clk);
    chk("rs_lat2", out_valid, 1);
    chk("rs_diff_after", diff, 8'h7F);
    chk("rs_ovf_after", overflow, 1);
    drain();

    // Random traffic with random back-pressure.
    @(posedge clk);
    #1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(3) != 0);
        a = 8'($urandom);
        b = 8'($urandom);
        bin = 1'($urandom);
      end
      out_ready = ($urandom_range(2) != 0);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
